qdma_target: RTL and testbench

Host-side DMA responder for the DELQA controller's DMA master port. It arbitrates bus mastership against host CPU activity and grants `dma_req`. Each granted `dma_stb` cycle is turned into one word access on a host-memory wishbone master port, and the cycle is terminated with `dma_ack`. If memory never answers, a non-existent-memory (NXM) timeout ends the cycle, so the controller cannot hang.

---
 rtl/qdma_target.sv | 80 ++++++++
 tb/tb_qdma_target.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/qdma_target.sv
// qdma_target: DMA responder granting the controller bus and running word accesses on a wishbone memory port with NXM timeout (clk_i, rst_ni, cpu_busy_i, dma_* controller side, mem_* memory side, nxm_o/nxm_clr_i, xfer_cnt_o)
module qdma_target #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_busy_i,
  input  logic        dma_req_i,
  output logic        dma_gnt_o,
  input  logic [21:0] dma_adr_i,
  input  logic [15:0] dma_dat_i,
  output logic [15:0] dma_dat_o,
  input  logic        dma_stb_i,
  input  logic        dma_we_i,
  output logic        dma_ack_o,
  output logic [20:0] mem_adr_o,
  output logic [15:0] mem_dat_o,
  input  logic [15:0] mem_dat_i,
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [1:0]  mem_sel_o,
  input  logic        mem_ack_i,
  output logic        nxm_o,
  input  logic        nxm_clr_i,
  output logic [15:0] xfer_cnt_o
);
  typedef enum logic [1:0] {IDLE, GRANT, ACCESS, ACK} state_t;
  state_t state, state_n;
  logic [7:0] tmo;
  logic [20:0] adr_q;
  logic [15:0] dat_q;
  logic we_q;
  logic acc, timeout;
  assign acc = state == ACCESS;
  assign timeout = tmo == 8'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    dma_gnt_o = state != IDLE;
    dma_ack_o = state == ACK;
    mem_cyc_o = acc;
    mem_stb_o = acc;
    mem_sel_o = {2{acc}};
    mem_we_o = acc & we_q;
    mem_adr_o = adr_q;
    mem_dat_o = dat_q;
    unique case (state)
      IDLE:    state_n = dma_req_i && !cpu_busy_i ? GRANT : IDLE;
      GRANT:   state_n = dma_stb_i ? ACCESS : dma_req_i ? GRANT : IDLE;
      ACCESS:  state_n = mem_ack_i || timeout ? ACK : ACCESS;
      default: state_n = dma_stb_i ? ACK : dma_req_i ? GRANT : IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      tmo <= '0;
      adr_q <= '0;
      dat_q <= '0;
      we_q <= 1'b0;
      dma_dat_o <= '0;
      nxm_o <= 1'b0;
      xfer_cnt_o <= '0;
    end else begin
      state <= state_n;
      tmo <= acc ? tmo + 8'd1 : 8'd0;
      if (state == GRANT && dma_stb_i) begin
        adr_q <= dma_adr_i[21:1];
        dat_q <= dma_dat_i;
        we_q <= dma_we_i;
      end
      // a late ack in the final timeout cycle still wins over NXM
      if (acc && (mem_ack_i ? !we_q : timeout))
        dma_dat_o <= mem_ack_i ? mem_dat_i : 16'd0;
      nxm_o <= (acc && timeout && !mem_ack_i) || (nxm_o && !nxm_clr_i);
      if (state == ACK && !dma_stb_i)
        xfer_cnt_o <= xfer_cnt_o + 16'd1;
    end
  end
endmodule

// File: tb/tb_qdma_target.sv
// tb_qdma_target: randomized self-checking bench for qdma_target against a transaction-level model
module tb_qdma_target;
  localparam int TMO = 8;
  logic clk_i = 0, rst_ni = 0, cpu_busy_i = 0, dma_req_i = 0, dma_stb_i = 0, dma_we_i = 0, nxm_clr_i = 0;
  logic [21:0] dma_adr_i = '0;
  logic [15:0] dma_dat_i = '0;
  logic dma_gnt_o, dma_ack_o, mem_cyc_o, mem_stb_o, mem_we_o, mem_ack_i, nxm_o;
  logic [15:0] dma_dat_o, mem_dat_o, mem_dat_i, xfer_cnt_o;
  logic [20:0] mem_adr_o;
  logic [1:0] mem_sel_o;
  logic [15:0] mem_m [64];
  logic [15:0] ref_m [64];
  int wait_n = 0;
  int acc_cyc = 0;
  int n_cmp = 0, n_bad = 0;
  logic m_nxm = 0, m_gnt = 0;
  logic [15:0] m_dat = 0, m_cnt = 0;

  qdma_target #(.TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cpu_busy_i(cpu_busy_i), .dma_req_i(dma_req_i), .dma_gnt_o(dma_gnt_o),
    .dma_adr_i(dma_adr_i), .dma_dat_i(dma_dat_i), .dma_dat_o(dma_dat_o), .dma_stb_i(dma_stb_i),
    .dma_we_i(dma_we_i), .dma_ack_o(dma_ack_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
    .mem_dat_i(mem_dat_i), .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
    .mem_sel_o(mem_sel_o), .mem_ack_i(mem_ack_i), .nxm_o(nxm_o), .nxm_clr_i(nxm_clr_i), .xfer_cnt_o(xfer_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // memory responder: acks after wait_n wait states, never when wait_n < 0
  always @(posedge clk_i) acc_cyc <= mem_stb_o ? acc_cyc + 1 : 0;
  assign mem_ack_i = mem_stb_o && wait_n >= 0 && acc_cyc == wait_n;
  assign mem_dat_i = mem_m[mem_adr_o[5:0]];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic get_grant(int busy_cyc);
    dma_req_i = 1;
    if (m_gnt) cpu_busy_i = 1'($urandom_range(0, 1));
    else begin
      cpu_busy_i = busy_cyc > 0;
      repeat (busy_cyc) begin @(negedge clk_i); chk("gnt_busy", dma_gnt_o, 0); end
      cpu_busy_i = 0;
      @(negedge clk_i);
      chk("gnt_lat", dma_gnt_o, 1);
      m_gnt = 1;
    end
  endtask

  task automatic xfer(logic [21:0] adr, logic [15:0] d, logic we, int w, int hold, logic keep_req, logic clr);
    int n = 0;
    logic [5:0] ix = adr[6:1];
    logic [20:0] wa = '0;
    logic [15:0] wd = '0;
    wait_n = w;
    dma_adr_i = adr; dma_dat_i = d; dma_we_i = we; dma_stb_i = 1;
    @(negedge clk_i);
    nxm_clr_i = clr;
    while (!dma_ack_o && n < TMO + 4) begin
      chk("mem_stb", mem_stb_o, 1);
      chk("mem_cyc", mem_cyc_o, 1);
      chk("mem_adr", mem_adr_o, adr[21:1]);
      chk("mem_sel", mem_sel_o, 2'b11);
      chk("mem_we", mem_we_o, we);
      chk("gnt_hold", dma_gnt_o, 1);
      if (we) chk("mem_dat", mem_dat_o, d);
      wa = mem_adr_o; wd = mem_dat_o;
      n++;
      @(negedge clk_i);
    end
    nxm_clr_i = 0;
    chk("stb_cycles", n, w < 0 ? TMO : w + 1);
    if (w < 0) begin m_nxm = 1; m_dat = 0; end
    else begin
      if (clr) m_nxm = 0;
      if (we) begin ref_m[ix] = d; mem_m[wa[5:0]] = wd; end
      else m_dat = ref_m[ix];
    end
    chk("ack", dma_ack_o, 1);
    chk("dat_o", dma_dat_o, m_dat);
    chk("nxm", nxm_o, m_nxm);
    chk("mem_cyc_off", mem_cyc_o, 0);
    repeat (hold) begin @(negedge clk_i); chk("ack_hold", dma_ack_o, 1); end
    dma_req_i = keep_req; dma_stb_i = 0;
    @(negedge clk_i);
    m_cnt++;
    m_gnt = keep_req;
    chk("ack_rel", dma_ack_o, 0);
    chk("xfer_cnt", xfer_cnt_o, m_cnt);
    chk("gnt_after", dma_gnt_o, m_gnt);
    chk("dat_hold", dma_dat_o, m_dat);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin mem_m[i] = 16'($urandom); ref_m[i] = mem_m[i]; end
    repeat (2) @(negedge clk_i);
    chk("rst_gnt", dma_gnt_o, 0);
    chk("rst_ack", dma_ack_o, 0);
    chk("rst_cyc", mem_cyc_o, 0);
    chk("rst_sel", mem_sel_o, 0);
    chk("rst_nxm", nxm_o, 0);
    chk("rst_cnt", xfer_cnt_o, 0);
    chk("rst_dat", dma_dat_o, 0);
    rst_ni = 1;
    @(negedge clk_i);
    // zero-wait read
    mem_m[6'h3f] = 16'o123456; ref_m[6'h3f] = 16'o123456;
    get_grant(0);
    xfer(22'o017776, 16'h0, 0, 0, 1, 1, 0);
    chk("rd_value", dma_dat_o, 16'o123456);
    // write with two wait states, then release the bus
    xfer(22'o000100, 16'o000777, 1, 2, 0, 0, 0);
    // arbitration against CPU activity, no preemption once granted
    get_grant(10);
    cpu_busy_i = 1;
    repeat (3) begin @(negedge clk_i); chk("no_preempt", dma_gnt_o, 1); end
    cpu_busy_i = 0;
    // ack landing in the last timeout cycle is a normal completion
    xfer(22'o000200, 16'h0, 0, TMO - 1, 0, 1, 0);
    // NXM, then NXM with clear held (set wins), then clear alone
    xfer(22'o000300, 16'h0, 0, -1, 0, 1, 0);
    xfer(22'o000302, 16'h1234, 1, -1, 0, 1, 1);
    nxm_clr_i = 1;
    @(negedge clk_i);
    nxm_clr_i = 0; m_nxm = 0;
    chk("nxm_clr", nxm_o, 0);
    // asynchronous reset while memory is stalled
    wait_n = -1;
    dma_adr_i = 22'o000400; dma_we_i = 0; dma_stb_i = 1;
    repeat (3) @(negedge clk_i);
    chk("pre_rst_cyc", mem_cyc_o, 1);
    #2 rst_ni = 0;
    #1;
    chk("async_cyc", mem_cyc_o, 0);
    chk("async_gnt", dma_gnt_o, 0);
    chk("async_ack", dma_ack_o, 0);
    @(negedge clk_i);
    dma_stb_i = 0; dma_req_i = 0; rst_ni = 1;
    m_cnt = 0; m_nxm = 0; m_dat = 0; m_gnt = 0;
    @(negedge clk_i);
    chk("post_rst_gnt", dma_gnt_o, 0);
    chk("post_rst_cnt", xfer_cnt_o, 0);
    chk("post_rst_adr", mem_adr_o, 0);
    chk("post_rst_dat", dma_dat_o, 0);
    // burst of three under one request, then drop the request
    get_grant(1);
    xfer(22'o001000, 16'h0, 0, 0, 0, 1, 0);
    xfer(22'o001002, 16'hbeef, 1, 1, 2, 1, 0);
    xfer(22'o001002, 16'h0, 0, 3, 0, 1, 0);
    chk("burst_cnt", xfer_cnt_o, 3);
    dma_req_i = 0;
    @(negedge clk_i);
    m_gnt = 0;
    chk("gnt_fall", dma_gnt_o, 0);
    // counter wrap
    get_grant(0);
    force dut.xfer_cnt_o = 16'hffff;
    #1 release dut.xfer_cnt_o;
    @(negedge clk_i);
    chk("cnt_preload", xfer_cnt_o, 16'hffff);
    m_cnt = 16'hffff;
    xfer(22'o002000, 16'h0, 0, 0, 0, 1, 0);
    chk("cnt_wrap", xfer_cnt_o, 0);
    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      get_grant(int'($urandom_range(0, 3)));
      xfer(22'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3)),
           int'($urandom_range(0, 2)), 1'($urandom), $urandom_range(0, 3) == 0);
      cpu_busy_i = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
